// File: rtl/mmio_pkg.sv
// Shared types and register map for the MMIO responder: FSM states,
// MMIO register offsets and push-button width.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [31:0] PB_STATE_OFS = 32'h0000_0000;
    localparam logic [31:0] PB_EDGE_OFS  = 32'h0000_0004;
    localparam logic [31:0] DISP_OFS     = 32'h0000_0008;
    localparam logic [31:0] CYCLES_OFS   = 32'h0000_000C;

    localparam int PB_W = 21;

    // Word address of an MMIO register given the window base and byte offset.
    function automatic logic [29:0] reg_word(input logic [31:0] base, input logic [31:0] ofs);
        return 30'((base + ofs) >> 2);
    endfunction

endpackage

// File: rtl/mmio_responder_pb_capture.sv
// Push-button front end: 2-flop synchronizer, rising-edge detect and a
// sticky edge register whose bits are cleared by a mask.
module pb_capture
    import mmio_pkg::*;
(
    input  logic            clk,
    input  logic            nRst,
    input  logic [PB_W-1:0] i_pb,
    input  logic [PB_W-1:0] i_clr,
    output logic [PB_W-1:0] o_sync,
    output logic [PB_W-1:0] o_edge
);

    logic [PB_W-1:0] r_meta;
    logic [PB_W-1:0] r_sync;
    logic [PB_W-1:0] r_sync_d;
    logic [PB_W-1:0] r_edge;
    logic [PB_W-1:0] w_rise;

    assign w_rise = r_sync & ~r_sync_d;

    // Synchronizer chain and sticky edges; a new edge wins over a clear.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_meta   <= {PB_W{1'b0}};
            r_sync   <= {PB_W{1'b0}};
            r_sync_d <= {PB_W{1'b0}};
            r_edge   <= {PB_W{1'b0}};
        end else begin
            r_meta   <= i_pb;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            r_edge   <= (r_edge & ~i_clr) | w_rise;
        end
    end

    assign o_sync = r_sync;
    assign o_edge = r_edge;

endmodule

// File: rtl/mmio_responder.sv
// Single-word request responder with fixed access latency, serving a word
// RAM and a small MMIO window (buttons, display register, cycle counter).
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] MMIO_BASE = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [20:0] pb,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        err,
    output logic [31:0] disp
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);
    localparam logic [29:0] RAM_WORDS = 30'(DEPTH);
    localparam logic [29:0] PBS_WORD  = reg_word(MMIO_BASE, PB_STATE_OFS);
    localparam logic [29:0] PBE_WORD  = reg_word(MMIO_BASE, PB_EDGE_OFS);
    localparam logic [29:0] DISP_WORD = reg_word(MMIO_BASE, DISP_OFS);
    localparam logic [29:0] CYC_WORD  = reg_word(MMIO_BASE, CYCLES_OFS);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [29:0]     r_word;
    logic [31:0]     r_wdata;
    logic            r_is_wr;
    logic [31:0]     r_data_out;
    logic [31:0]     r_disp;
    logic [31:0]     r_cycles;
    logic            r_err;
    logic            r_edge_rd;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_commit;
    logic [29:0]     w_word;
    logic [31:0]     w_wdata;
    logic            w_is_wr;
    logic            w_ram_hit;
    logic            w_pbs_hit;
    logic            w_pbe_hit;
    logic            w_disp_hit;
    logic            w_cyc_hit;
    logic            w_unmapped;
    logic [31:0]     w_rdata;
    logic [PB_W-1:0] w_pb_sync;
    logic [PB_W-1:0] w_pb_edge;
    logic [PB_W-1:0] w_pb_clr;
    logic [1:0]      w_unused_addr;

    assign w_unused_addr = addr[1:0];
    assign w_req         = ren | wen;

    // In IDLE the live request is used so a 1-cycle latency can commit at acceptance.
    assign w_word  = (r_state == IDLE) ? addr[31:2] : r_word;
    assign w_wdata = (r_state == IDLE) ? data_in    : r_wdata;
    assign w_is_wr = (r_state == IDLE) ? wen        : r_is_wr;

    // Next-state logic and commit strobe at the last busy cycle.
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (LATENCY == 1) begin
                        w_next   = DONE;
                        w_commit = 1'b1;
                    end else begin
                        w_next   = ACCESS;
                    end
                end else begin
                    w_next = IDLE;
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd1) begin
                    w_next   = DONE;
                    w_commit = 1'b1;
                end else begin
                    w_next   = ACCESS;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register, latency counter and request latch.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_word  <= 30'd0;
            r_wdata <= 32'd0;
            r_is_wr <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_cnt   <= LAT_M1;
                r_word  <= addr[31:2];
                r_wdata <= data_in;
                r_is_wr <= wen;
            end else if (r_state == ACCESS) begin
                r_cnt   <= r_cnt - 4'd1;
            end
        end
    end

    assign w_ram_hit  = (w_word < RAM_WORDS);
    assign w_pbs_hit  = (w_word == PBS_WORD);
    assign w_pbe_hit  = (w_word == PBE_WORD);
    assign w_disp_hit = (w_word == DISP_WORD);
    assign w_cyc_hit  = (w_word == CYC_WORD);
    assign w_unmapped = ~(w_ram_hit | w_pbs_hit | w_pbe_hit | w_disp_hit | w_cyc_hit);

    // Read-data mux over RAM and MMIO registers; unmapped reads return zero.
    always_comb begin
        w_rdata = 32'd0;
        if (w_ram_hit) begin
            w_rdata = r_mem[w_word[AW-1:0]];
        end else if (w_pbs_hit) begin
            w_rdata = {11'd0, w_pb_sync};
        end else if (w_pbe_hit) begin
            w_rdata = {11'd0, w_pb_edge};
        end else if (w_disp_hit) begin
            w_rdata = r_disp;
        end else if (w_cyc_hit) begin
            w_rdata = r_cycles;
        end else begin
            w_rdata = 32'd0;
        end
    end

    // Result registers, display register and free-running cycle counter.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_data_out <= 32'd0;
            r_disp     <= 32'd0;
            r_cycles   <= 32'd0;
            r_err      <= 1'b0;
            r_edge_rd  <= 1'b0;
        end else begin
            r_cycles  <= r_cycles + 32'd1;
            r_err     <= w_commit & w_unmapped;
            r_edge_rd <= w_commit & ~w_is_wr & w_pbe_hit;
            if (w_commit && !w_is_wr) begin
                r_data_out <= w_rdata;
            end
            if (w_commit && w_is_wr && w_disp_hit) begin
                r_disp <= w_wdata;
            end
        end
    end

    // Word RAM; contents survive reset, and no write commits while reset is held.
    always_ff @(posedge clk) begin
        if (nRst && w_commit && w_is_wr && w_ram_hit) begin
            r_mem[w_word[AW-1:0]] <= w_wdata;
        end
    end

    // Only the bits actually returned by a PB_EDGE read are cleared.
    assign w_pb_clr = (r_state == DONE && r_edge_rd) ? r_data_out[PB_W-1:0] : {PB_W{1'b0}};

    pb_capture u_pb_capture (
        .clk    (clk),
        .nRst   (nRst),
        .i_pb   (pb),
        .i_clr  (w_pb_clr),
        .o_sync (w_pb_sync),
        .o_edge (w_pb_edge)
    );

    assign busy     = ((r_state == IDLE) && w_req) || (r_state == ACCESS);
    assign data_out = r_data_out;
    assign err      = r_err;
    assign disp     = r_disp;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed accesses with literal expectations plus a
// transaction-level model compared against the outputs on every cycle.
module tb_mmio_responder;

    localparam int          L     = 2;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        nRst;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [20:0] pb;
    logic [31:0] data_out;
    logic        busy;
    logic        err;
    logic [31:0] disp;

    always #5 clk = ~clk;

    mmio_responder #(.DEPTH(DEPTH), .LATENCY(L), .MMIO_BASE(BASE)) dut (
        .clk      (clk),
        .nRst     (nRst),
        .ren      (ren),
        .wen      (wen),
        .addr     (addr),
        .data_in  (data_in),
        .pb       (pb),
        .data_out (data_out),
        .busy     (busy),
        .err      (err),
        .disp     (disp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_t: -1 when idle, otherwise cycles since acceptance (L is the result cycle).
    int          m_t      = -1;
    int          m_cycles = 0;
    logic [31:0] m_dout   = 32'd0;
    logic [31:0] m_disp   = 32'd0;
    logic [20:0] m_edge   = 21'd0;
    logic        m_err    = 1'b0;
    logic        m_edge_rd = 1'b0;
    logic        m_wr     = 1'b0;
    logic [31:0] m_a      = 32'd0;
    logic [31:0] m_d      = 32'd0;
    logic [31:0] m_mem [0:DEPTH-1];
    logic [20:0] samp  [0:4095];
    logic [20:0] md_s_now;
    logic [20:0] md_s_prev;
    logic [20:0] md_clr;
    int          md_rel;

    // Synchronized button value seen in cycle c is the raw value of cycle c-2.
    function automatic logic [20:0] sync_at(input int c);
        if (c < 0) return 21'd0;
        return samp[c % 4096];
    endfunction

    task automatic model_commit(input logic [20:0] s_now);
        logic [31:0] val;
        logic [31:0] wa;
        val       = 32'd0;
        m_err     = 1'b0;
        m_edge_rd = 1'b0;
        wa        = {m_a[31:2], 2'b00};
        if (wa < DEPTH * 4) begin
            if (m_wr) m_mem[wa / 4] = m_d;
            else      val = m_mem[wa / 4];
        end else if (wa == BASE) begin
            val = {11'd0, s_now};
        end else if (wa == BASE + 32'd4) begin
            val = {11'd0, m_edge};
            m_edge_rd = !m_wr;
        end else if (wa == BASE + 32'd8) begin
            if (m_wr) m_disp = m_d;
            else      val = m_disp;
        end else if (wa == BASE + 32'd12) begin
            val = m_cycles;
        end else begin
            m_err = 1'b1;
        end
        if (!m_wr) m_dout = val;
    endtask

    initial forever begin
        @(posedge clk or negedge nRst);
        if (!nRst) begin
            m_t = -1; m_cycles = 0; m_dout = 32'd0; m_disp = 32'd0;
            m_edge = 21'd0; m_err = 1'b0; m_edge_rd = 1'b0; samp[0] = 21'd0;
        end else begin
            md_s_now  = sync_at(m_cycles - 1);
            md_s_prev = sync_at(m_cycles - 2);
            md_clr    = (m_t == L && m_edge_rd) ? m_dout[20:0] : 21'd0;
            md_rel    = (m_t < 0 && (ren || wen)) ? 0 : m_t;
            if (md_rel == 0 && m_t < 0) begin
                m_wr = wen; m_a = addr; m_d = data_in;
            end
            if (md_rel == L - 1) model_commit(md_s_now);
            m_edge = (m_edge & ~md_clr) | (md_s_now & ~md_s_prev);
            m_t    = (md_rel >= 0 && md_rel < L) ? md_rel + 1 : -1;
            samp[(m_cycles + 1) % 4096] = pb;
            m_cycles++;
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        check("busy", {31'd0, busy}, {31'd0, ((m_t < 0) && (ren || wen)) || (m_t >= 1 && m_t < L)});
        check("err", {31'd0, err}, {31'd0, (m_t == L) && m_err});
        check("data_out", data_out, m_dout);
        check("disp", disp, m_disp);
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] dout;
    logic        er;
    int          nb;

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                             input bit set_pb, input logic [20:0] pbv,
                             output logic [31:0] o_dout, output logic o_err, output int o_nb);
        bit done;
        @(posedge clk);
        #1;
        wen = wr; ren = rd; addr = a; data_in = d;
        if (set_pb) pb = pbv;
        o_nb = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (busy) o_nb++;
            else done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_timeout: busy still high after 20 cycles, addr 0x%08h", a);
        end
        o_dout = data_out;
        o_err  = err;
        #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRst = 1'b0; ren = 1'b0; wen = 1'b0; addr = 32'd0; data_in = 32'd0; pb = 21'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_disp", disp, 32'd0);
        nRst = 1'b1;

        do_access(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 21'd0, dout, er, nb);
        check("wr_busy_cycles", nb, 32'd2);
        check("wr_err", {31'd0, er}, 32'd0);
        do_access(1'b0, 1'b1, 32'h10, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("rd_busy_cycles", nb, 32'd2);
        check("rd_data", dout, 32'hDEAD_BEEF);
        check("model_rd_data", m_dout, 32'hDEAD_BEEF);

        do_access(1'b0, 1'b1, 32'h8000, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("unmapped_rd_data", dout, 32'd0);
        check("unmapped_rd_err", {31'd0, er}, 32'd1);

        do_access(1'b1, 1'b0, 32'hF008, 32'h1234_5678, 1'b0, 21'd0, dout, er, nb);
        check("disp_wr_err", {31'd0, er}, 32'd0);
        check("disp_reg", disp, 32'h1234_5678);
        do_access(1'b0, 1'b1, 32'hF008, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("disp_rd", dout, 32'h1234_5678);

        do_access(1'b1, 1'b0, 32'h8000, 32'd1, 1'b0, 21'd0, dout, er, nb);
        check("unmapped_wr_err", {31'd0, er}, 32'd1);
        do_access(1'b1, 1'b0, 32'hF00C, 32'hFFFF_FFFF, 1'b0, 21'd0, dout, er, nb);
        check("ro_wr_err", {31'd0, er}, 32'd0);

        // Button raised in the acceptance cycle is not yet synchronized at sample time.
        do_access(1'b0, 1'b1, 32'hF000, 32'd0, 1'b1, 21'h8, dout, er, nb);
        check("pb_state_early", dout, 32'd0);
        do_access(1'b0, 1'b1, 32'hF000, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("pb_state", dout, 32'h8);
        do_access(1'b0, 1'b1, 32'hF004, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("pb_edge_first", dout, 32'h8);
        do_access(1'b0, 1'b1, 32'hF004, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("pb_edge_cleared", dout, 32'd0);

        @(posedge clk); #1 pb = 21'd0;
        repeat (4) @(posedge clk);
        #1 pb = 21'h8;
        repeat (4) @(posedge clk);
        #1 pb = 21'd0;
        repeat (4) @(posedge clk);
        // This rise reaches the sticky register in the DONE (clear) cycle of the read.
        do_access(1'b0, 1'b1, 32'hF004, 32'd0, 1'b1, 21'h8, dout, er, nb);
        check("pb_edge_before_clr", dout, 32'h8);
        do_access(1'b0, 1'b1, 32'hF004, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("pb_edge_kept", dout, 32'h8);
        do_access(1'b0, 1'b1, 32'hF004, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("pb_edge_final", dout, 32'd0);

        do_access(1'b1, 1'b1, 32'h20, 32'd5, 1'b0, 21'd0, dout, er, nb);
        do_access(1'b0, 1'b1, 32'h20, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("wen_wins", dout, 32'd5);
        do_access(1'b0, 1'b1, 32'hF00C, 32'd0, 1'b0, 21'd0, dout, er, nb);

        do_access(1'b1, 1'b0, 32'h24, 32'hAAAA_5555, 1'b0, 21'd0, dout, er, nb);
        @(posedge clk);
        #1;
        wen = 1'b1; addr = 32'h24; data_in = 32'h1111_1111;
        @(posedge clk);
        #1;
        nRst = 1'b0; wen = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        check("rst_mid_disp", disp, 32'd0);
        do_access(1'b0, 1'b1, 32'hF00C, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("cycles_after_rst", dout, 32'd2);
        do_access(1'b0, 1'b1, 32'h24, 32'd0, 1'b0, 21'd0, dout, er, nb);
        check("rst_lost_write", dout, 32'hAAAA_5555);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Responder end of the request unit's RAM port: accepts single-word read/write requests, holds `busy` for a fixed access latency, then returns data. Serves an on-chip word RAM plus a small memory-mapped I/O window: synchronized push buttons with sticky edge capture, a display register and a cycle counter. Sits in `top1` between the CPU request unit and the FPGA I/O, giving the single-cycle core one shared data/instruction memory with visible I/O.

## Interface
- `DEPTH`, 64: RAM words; power of two, 16–1024.
- `LATENCY`, 2: cycles `busy` is high per access; 1–15.
- `MMIO_BASE`, 32'h0000_F000: byte base of the MMIO window.
- `clk`  in  1  system clock.
- `nRst`  in  1  reset, asynchronous, active-low.
- `ren`  in  1  read request.
- `wen`  in  1  write request; wins over `ren` if both are high.
- `addr`  in  32  byte address; `addr[1:0]` ignored.
- `data_in`  in  32  write data.
- `pb`  in  21  raw push buttons, asynchronous.
- `data_out`  out  32  read data, valid in the DONE cycle.
- `busy`  out  1  access in progress.
- `err`  out  1  one-cycle pulse in DONE for an unmapped address.
- `disp`  out  32  display register contents.

## Operation
- FSM states are IDLE, ACCESS and DONE.
  - IDLE, with `ren|wen` high: latch `addr`, `data_in` and the op; load the counter with `LATENCY-1`; go to ACCESS. If `LATENCY==1`, go straight to DONE.
  - ACCESS: decrement the counter; at 0, commit the write or sample the read, then go to DONE.
  - DONE: present the result for one cycle; go to IDLE. A request seen in DONE is ignored.
- `busy` is combinational: `(IDLE & (ren|wen)) | ACCESS`.
- Decode uses the latched word address:
  - RAM hit when `addr < DEPTH*4`; index `addr[$clog2(DEPTH)+1:2]`.
  - `MMIO_BASE+0x0` PB_STATE: RO, `{11'b0, pb_sync}`.
  - `+0x4` PB_EDGE: RO, sticky rising edges. A read clears the bits that were read, in the DONE cycle.
  - `+0x8` DISP: RW.
  - `+0xC` CYCLES: RO, free-running 32-bit counter that wraps.
- Writes to RO registers are dropped silently with no `err`.
- Unmapped access: a read returns 0, a write is dropped, and `err` pulses.
- Push buttons pass through a 2-flop synchronizer. An edge sets a bit when `pb_sync & ~pb_sync_d`.
- If an edge occurs in the same cycle as a clear, the bit stays set.
- `data_out` holds its value outside DONE; it changes only at the DONE entry edge.

## Timing
- Reset values: FSM IDLE, `busy` 0, `data_out` 0, `err` 0, `disp` 0, PB_EDGE 0, CYCLES 0, synchronizer flops 0. RAM contents are not reset.
- Request accepted at cycle 0:
  - `busy` is high in cycles 0 to `LATENCY-1`.
  - Write commit or read sample happens at the end of cycle `LATENCY-1`.
  - DONE is cycle `LATENCY`: `busy` 0, `data_out` and `err` valid.
  - Next acceptance is possible in cycle `LATENCY+1`. Throughput is one access per `LATENCY+1` cycles.
- The initiator holds `addr`, `data_in`, `ren` and `wen` while `busy` is high, and drops `ren`/`wen` in DONE. The responder uses only the values latched at cycle 0.
- Button latency: a `pb` change appears in PB_STATE 2 cycles later and in PB_EDGE 3 cycles later.
- Reset asserted mid-access: the FSM goes to IDLE immediately. A write whose commit edge has not occurred is lost.
- Read-after-write to the same RAM word returns the new data.

## Structure
- Package `mmio_pkg` holds:
  - `state_t` enum (IDLE, ACCESS, DONE);
  - localparams for the MMIO offsets (`PB_STATE_OFS`, `PB_EDGE_OFS`, `DISP_OFS`, `CYCLES_OFS`);
  - a `PB_W=21` constant.
- Sub-module `pb_capture`: synchronizer, rising-edge detector and sticky register with a clear mask input.

## Test plan
- Write, then read with `LATENCY=2`:
  - write `0xDEADBEEF` to addr `0x10`: `busy` is high for 2 cycles, `err` stays 0;
  - then read `0x10`: `data_out=0xDEADBEEF` in cycle 2 with `busy=0`.
- Unmapped read of `0x8000`: `data_out=0`, `err` pulses exactly one cycle in DONE.
- DISP: write `0x12345678` to `0xF008`: `disp=0x12345678` from the DONE cycle; a read of `0xF008` returns the same.
- Buttons:
  - pulse `pb[3]` high: PB_STATE bit 3 is set after 2 cycles;
  - a PB_EDGE read returns `0x8`, then the next read returns `0`;
  - a new edge landing in the clear cycle leaves bit 3 set.
- `wen` and `ren` together to `0x20` with `data_in=5`: treated as a write; a following read returns 5.
- Pull `nRst` low during ACCESS of a write: `busy` drops at once and the RAM word is unchanged; CYCLES resets to 0.
